// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer: walks the 3-to-1 mux select U->V->W on a
// timed dwell or a manual press, logging each captured mux output.
module mux_select_sequencer #(
   parameter int DWELL = 50_000_000,
   parameter int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       step_n,
   input  logic       auto,
   input  logic       hold,
   input  logic [1:0] M_in,
   output logic [1:0] sel,
   output logic [1:0] slot,
   output logic [5:0] hist,
   output logic       valid
);

   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {
      S_U = 2'd0,
      S_V = 2'd1,
      S_W = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_sync0;
   logic            r_sync1;
   logic            r_prev;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_cap;
   logic [1:0]      r_sel;
   logic [1:0]      r_slot;
   logic [5:0]      r_hist;
   logic            w_press;
   logic            w_tick;
   logic            w_adv;
   logic [1:0]      w_sel;
   logic [1:0]      w_slot;

   always_comb begin
      w_press = r_prev & ~r_sync1;
      w_tick  = (r_cnt == LAST);
      w_adv   = auto ? (w_tick & ~hold) : (w_press & ~hold);
      w_next  = r_state;
      if (w_adv) begin
         unique case (r_state)
            S_U:     w_next = S_V;
            S_V:     w_next = S_W;
            S_W:     w_next = S_U;
            default: w_next = S_U;
         endcase
      end
      // sel[0] wins inside the mux, so W is 01 and 11 is never used
      w_sel  = 2'b00;
      w_slot = 2'd0;
      unique case (w_next)
         S_U: begin
            w_sel  = 2'b00;
            w_slot = 2'd0;
         end
         S_V: begin
            w_sel  = 2'b10;
            w_slot = 2'd1;
         end
         S_W: begin
            w_sel  = 2'b01;
            w_slot = 2'd2;
         end
         default: begin
            w_sel  = 2'b00;
            w_slot = 2'd0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_state <= S_U;
         r_sel   <= 2'b00;
         r_slot  <= 2'd0;
      end else begin
         r_state <= w_next;
         r_sel   <= w_sel;
         r_slot  <= w_slot;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         r_sync0 <= 1'b1;
         r_sync1 <= 1'b1;
         r_prev  <= 1'b1;
         r_cnt   <= '0;
         r_cap   <= 2'd0;
         r_hist  <= 6'd0;
      end else begin
         r_sync0 <= step_n;
         r_sync1 <= r_sync0;
         r_prev  <= r_sync1;
         if (!auto) begin
            r_cnt <= '0;
         end else if (!hold) begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         end
         if (w_adv) begin
            r_hist <= {r_hist[3:0], M_in};
            if (r_cap != 2'd3) begin
               r_cap <= r_cap + 2'd1;
            end
         end
      end
   end

   assign sel   = r_sel;
   assign slot  = r_slot;
   assign hist  = r_hist;
   assign valid = (r_cap == 2'd3);

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb_mux_select_sequencer: DWELL=4 and DWELL=1 instances checked
// each edge against a slot/queue model of the sequencer rules.
module tb_mux_select_sequencer;

   logic       Clock = 1'b0;
   logic       Resetn;
   logic       step_n;
   logic       auto;
   logic       hold;
   logic [1:0] chan [3];
   logic [1:0] m4, m1;
   logic [1:0] sel4, sel1;
   logic [1:0] slot4, slot1;
   logic [5:0] hist4, hist1;
   logic       valid4, valid1;

   int n_chk = 0;
   int n_err = 0;

   int DW [2] = '{4, 1};
   int m_slot [2];
   int m_hist [2];
   int m_cap [2];
   int m_cnt [2];
   bit s1, s2, s3;

   always #5 Clock = ~Clock;

   // board mux: sel[0] selects W regardless of sel[1]
   always_comb begin
      m4 = sel4[0] ? chan[2] : (sel4[1] ? chan[1] : chan[0]);
      m1 = sel1[0] ? chan[2] : (sel1[1] ? chan[1] : chan[0]);
   end

   mux_select_sequencer #(.DWELL(4)) u_dw4 (
      .Clock(Clock), .Resetn(Resetn), .step_n(step_n),
      .auto(auto), .hold(hold), .M_in(m4),
      .sel(sel4), .slot(slot4), .hist(hist4), .valid(valid4)
   );

   mux_select_sequencer #(.DWELL(1)) u_dw1 (
      .Clock(Clock), .Resetn(Resetn), .step_n(step_n),
      .auto(auto), .hold(hold), .M_in(m1),
      .sel(sel1), .slot(slot1), .hist(hist1), .valid(valid1)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] sel_of(input int s);
      logic [1:0] tab [3];
      tab = '{2'b00, 2'b10, 2'b01};
      return tab[s];
   endfunction

   task automatic model_edge();
      bit press;
      bit adv;
      if (!Resetn) begin
         for (int i = 0; i < 2; i++) begin
            m_slot[i] = 0;
            m_hist[i] = 0;
            m_cap[i]  = 0;
            m_cnt[i]  = 0;
         end
         s1 = 1; s2 = 1; s3 = 1;
      end else begin
         press = s3 && !s2;
         for (int i = 0; i < 2; i++) begin
            adv = 0;
            if (auto) begin
               if (!hold) begin
                  if (m_cnt[i] == DW[i] - 1) begin
                     adv = 1;
                     m_cnt[i] = 0;
                  end else begin
                     m_cnt[i]++;
                  end
               end
            end else begin
               m_cnt[i] = 0;
               adv = press && !hold;
            end
            if (adv) begin
               m_hist[i] = ((m_hist[i] << 2) | int'(chan[m_slot[i]])) & 63;
               m_slot[i] = (m_slot[i] + 1) % 3;
               if (m_cap[i] < 3) m_cap[i]++;
            end
         end
         s3 = s2; s2 = s1; s1 = step_n;
      end
   endtask

   task automatic cyc();
      @(posedge Clock);
      model_edge();
      #1;
      chk("sel4",   {6'd0, sel4},   {6'd0, sel_of(m_slot[0])});
      chk("slot4",  {6'd0, slot4},  8'(m_slot[0]));
      chk("hist4",  {2'd0, hist4},  8'(m_hist[0]));
      chk("valid4", {7'd0, valid4}, {7'd0, m_cap[0] == 3});
      chk("sel1",   {6'd0, sel1},   {6'd0, sel_of(m_slot[1])});
      chk("slot1",  {6'd0, slot1},  8'(m_slot[1]));
      chk("hist1",  {2'd0, hist1},  8'(m_hist[1]));
      chk("valid1", {7'd0, valid1}, {7'd0, m_cap[1] == 3});
      @(negedge Clock);
   endtask

   task automatic press();
      step_n = 1'b0;
      cyc(); cyc();
      step_n = 1'b1;
      cyc(); cyc(); cyc();
   endtask

   task automatic do_reset();
      Resetn = 1'b0;
      cyc(); cyc();
      Resetn = 1'b1;
   endtask

   initial begin
      s1 = 1; s2 = 1; s3 = 1;
      chan = '{2'b01, 2'b10, 2'b11};
      Resetn = 1'b0;
      step_n = 1'($urandom);
      auto   = 1'($urandom);
      hold   = 1'($urandom);
      cyc();
      step_n = 1'($urandom);
      auto   = 1'($urandom);
      hold   = 1'($urandom);
      cyc();
      chk("rst_sel",   {6'd0, sel4},   8'h00);
      chk("rst_hist",  {2'd0, hist4},  8'h00);
      chk("rst_valid", {7'd0, valid4}, 8'h00);

      Resetn = 1'b1; auto = 1'b0; hold = 1'b0; step_n = 1'b1;
      repeat (4) cyc();
      chk("idle_sel", {6'd0, sel4}, 8'h00);

      press();
      chk("walk1_sel", {6'd0, sel4}, 8'h02);
      press();
      chk("walk2_sel", {6'd0, sel4}, 8'h01);
      press();
      chk("walk3_sel",   {6'd0, sel4},   8'h00);
      chk("walk3_hist",  {2'd0, hist4},  8'h1b);
      chk("walk3_valid", {7'd0, valid4}, 8'h01);
      chk("walk3_hist1", {2'd0, hist1},  8'h1b);
      press();
      chk("walk4_sel",  {6'd0, sel4},  8'h02);
      chk("walk4_hist", {2'd0, hist4}, 8'h2d);

      step_n = 1'b0;
      repeat (20) cyc();
      step_n = 1'b1;
      repeat (3) cyc();
      chk("long_sel", {6'd0, sel4}, 8'h01);

      do_reset();
      auto = 1'b1;
      repeat (14) cyc();

      do_reset();
      auto = 1'b1;
      repeat (3) cyc();
      hold = 1'b1;
      repeat (5) cyc();
      chk("hold_sel", {6'd0, sel4}, 8'h00);
      hold = 1'b0;
      cyc();
      chk("unhold_sel", {6'd0, sel4}, 8'h02);
      auto = 1'b0; hold = 1'b1;
      press();
      hold = 1'b0;
      repeat (3) cyc();
      chk("holdpress_sel", {6'd0, sel4}, 8'h02);
      auto = 1'b1;
      press();

      do_reset();
      auto = 1'b1;
      repeat (3) cyc();
      Resetn = 1'b0;
      cyc();
      chk("rsttick_sel",  {6'd0, sel4},  8'h00);
      chk("rsttick_hist", {2'd0, hist4}, 8'h00);
      Resetn = 1'b1;

      for (int n = 0; n < 1500; n++) begin
         Resetn = ($urandom_range(199) != 0);
         if ($urandom_range(39) == 0) auto = ~auto;
         hold = ($urandom_range(9) == 0);
         if ($urandom_range(3) == 0) step_n = ~step_n;
         if ($urandom_range(29) == 0) begin
            chan[$urandom_range(2)] = 2'($urandom);
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
